// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with zero-latency hits and a
// line-refill FSM that fetches one word per backing-memory handshake.
module icache_dm #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int LOG2_LINES = 4,
  parameter int LOG2_WORDS = 2,
  parameter int TWIDTH     = AWIDTH - LOG2_LINES - LOG2_WORDS - 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_pc,
  input  logic              i_flush,
  output logic              o_valid,
  output logic              o_stall,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_mem_rq,
  output logic [AWIDTH-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DWIDTH-1:0] i_mem_data
);

  localparam int LINES = 1 << LOG2_LINES;
  localparam int WORDS = 1 << LOG2_WORDS;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q;
  logic [TWIDTH-1:0]       fill_tag_q;
  logic [LOG2_LINES-1:0]   fill_index_q;
  logic [LOG2_WORDS-1:0]   count_q;
  logic                    flush_pend_q;
  logic                    start_fill;
  logic                    hit;

  logic [TWIDTH-1:0]       tag_mem  [LINES];
  logic [DWIDTH-1:0]       data_mem [LINES][WORDS];

  logic [TWIDTH-1:0]       pc_tag;
  logic [LOG2_LINES-1:0]   pc_index;
  logic [LOG2_WORDS-1:0]   pc_offset;
  logic [1:0]              unused_pc_lsb;

  assign pc_tag        = i_pc[AWIDTH-1 -: TWIDTH];
  assign pc_index      = i_pc[LOG2_WORDS+2 +: LOG2_LINES];
  assign pc_offset     = i_pc[2 +: LOG2_WORDS];
  assign unused_pc_lsb = i_pc[1:0];

  wire last_word = &count_q;
  wire fill_ack  = (state_q == REFILL) && i_mem_ack;

  assign hit = i_req && valid_q[pc_index] && (tag_mem[pc_index] == pc_tag);

  // Outputs are gated by reset so a refill abort drops o_mem_rq without a clock.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d    = state_q;
    start_fill = 1'b0;
    o_valid    = 1'b0;
    o_stall    = 1'b0;
    o_data     = '0;
    o_mem_rq   = 1'b0;
    o_mem_addr = '0;
    if (i_reset_n) begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            o_valid = 1'b1;
            o_data  = data_mem[pc_index][pc_offset];
          end else if (i_req) begin
            o_stall    = 1'b1;
            start_fill = 1'b1;
            state_d    = REFILL;
          end
        end
        REFILL: begin
          o_stall    = i_req;
          o_mem_rq   = 1'b1;
          o_mem_addr = {fill_tag_q, fill_index_q, count_q, 2'b00};
          if (i_mem_ack && last_word) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      fill_tag_q   <= '0;
      fill_index_q <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q <= state_d;
      if (i_flush) valid_q <= '0;
      if (start_fill) begin
        fill_tag_q   <= pc_tag;
        fill_index_q <= pc_index;
        count_q      <= '0;
      end
      if (state_q == IDLE) begin
        flush_pend_q <= 1'b0;
      end else begin
        if (i_flush) flush_pend_q <= 1'b1;
        if (i_mem_ack) begin
          count_q <= count_q + 1'b1;
          // A flush anywhere in this refill, including the final ack cycle, leaves the line invalid.
          if (last_word && !flush_pend_q && !i_flush) valid_q[fill_index_q] <= 1'b1;
        end
      end
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits alone guard them.
  always_ff @(posedge i_clk) begin
    if (fill_ack) begin
      data_mem[fill_index_q][count_q] <= i_mem_data;
      if (last_word) tag_mem[fill_index_q] <= fill_tag_q;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm with a latency-configurable
// backing memory returning addr ^ 32'hA5A5_0000.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        valid, stall, mem_rq, mem_ack;
  logic [31:0] data, mem_addr, mem_data;

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat = 1;
  int          wait_cnt = 0;
  logic [31:0] ack_log[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;

  icache_dm dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_req      (req),
    .i_pc       (pc),
    .i_flush    (flush),
    .o_valid    (valid),
    .o_stall    (stall),
    .o_data     (data),
    .o_mem_rq   (mem_rq),
    .o_mem_addr (mem_addr),
    .i_mem_ack  (mem_ack),
    .i_mem_data (mem_data)
  );

  always #5 clk = ~clk;

  assign mem_ack  = mem_rq && (wait_cnt >= lat - 1);
  assign mem_data = mem_ack ? (mem_addr ^ 32'hA5A5_0000) : 32'h0;

  always @(posedge clk) begin
    if (!mem_rq || mem_ack) wait_cnt <= 0;
    else                    wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Log acked addresses and check the request address is held across wait cycles.
  always @(negedge clk) begin
    if (prev_hold && mem_rq) check("addr_hold", mem_addr, prev_addr);
    if (mem_ack) ack_log.push_back(mem_addr);
    prev_hold = mem_rq && !mem_ack;
    prev_addr = mem_addr;
  end

  // Called at posedge+1; requests pc until a hit, counting stall cycles.
  task automatic fetch(input logic [31:0] fpc, output int stalls, output logic [31:0] fdata);
    logic got_hit;
    got_hit = 1'b0;
    stalls  = 0;
    fdata   = '0;
    req = 1'b1;
    pc  = fpc;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (valid) begin
        fdata   = data;
        got_hit = 1'b1;
        break;
      end
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    if (!got_hit) check("fetch_timeout", 32'(got_hit), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] hpc, input logic [31:0] exp);
    req = 1'b1;
    pc  = hpc;
    @(negedge clk);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_data"}, data, exp);
    check({tag, "_rq"}, 32'(mem_rq), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic check_log(input string tag, input logic [31:0] base, input int reps);
    check({tag, "_size"}, 32'(ack_log.size()), 32'(4 * reps));
    for (int i = 0; i < ack_log.size() && i < 4 * reps; i++)
      check({tag, "_addr"}, ack_log[i], base + 32'((i % 4) * 4));
  endtask

  // Called at posedge+1 with a miss under way; returns at posedge+1 after 2 acks.
  task automatic wait_two_acks(input string tag);
    int n;
    n = 0;
    for (int k = 0; k < 50 && n < 2; k++) begin
      @(negedge clk);
      if (mem_ack) n++;
      @(posedge clk); #1;
    end
    check({tag, "_two_acks"}, 32'(n), 32'd2);
  endtask

  initial begin
    int          st;
    logic [31:0] d;

    // Reset state, with a request pending to exercise output gating.
    req = 1'b1;
    pc  = 32'h40;
    #3;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_rq", 32'(mem_rq), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. Cold miss.
    ack_log.delete();
    fetch(32'h40, st, d);
    check("cold_stalls", 32'(st), 32'd5);
    check("cold_data", d, 32'hA5A5_0040);
    check_log("cold", 32'h40, 1);

    // 2. Hits, low address bits ignored.
    expect_hit("hit_4c", 32'h4C, 32'hA5A5_004C);
    expect_hit("hit_41", 32'h41, 32'hA5A5_0040);

    // 3. Conflict miss with a 3-cycle memory, then the evicted line misses.
    lat = 3;
    ack_log.delete();
    fetch(32'h140, st, d);
    check("slow_stalls", 32'(st), 32'd13);
    check("slow_data", d, 32'hA5A5_0140);
    check_log("slow", 32'h140, 1);
    lat = 1;
    ack_log.delete();
    fetch(32'h40, st, d);
    check("evict_stalls", 32'(st), 32'd5);
    check("evict_data", d, 32'hA5A5_0040);

    // 4. Flush in IDLE: coincident request still hits, the next one misses.
    req   = 1'b1;
    pc    = 32'h44;
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_valid", 32'(valid), 32'd1);
    check("flush_idle_data", data, 32'hA5A5_0044);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_valid", 32'(valid), 32'd0);
    check("post_flush_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_flush_rq", 32'(mem_rq), 32'd1);
    check("post_flush_addr", mem_addr, 32'h40);
    @(posedge clk); #1;
    fetch(32'h44, st, d);
    check("post_flush_data", d, 32'hA5A5_0044);

    // 5. Flush mid-refill: refill completes but the line must be refetched.
    ack_log.delete();
    req = 1'b1;
    pc  = 32'h80;
    @(posedge clk); #1;
    wait_two_acks("midflush");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    fetch(32'h80, st, d);
    check("midflush_data", d, 32'hA5A5_0080);
    check_log("midflush", 32'h80, 2);

    // 6. Async reset mid-refill drops the request between edges.
    ack_log.delete();
    req = 1'b1;
    pc  = 32'h40;
    @(posedge clk); #1;
    wait_two_acks("arst");
    check("arst_rq_before", 32'(mem_rq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rq", 32'(mem_rq), 32'd0);
    check("arst_addr", mem_addr, 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ack_log.delete();
    fetch(32'h40, st, d);
    check("arst_stalls", 32'(st), 32'd5);
    check("arst_data", d, 32'hA5A5_0040);
    check_log("arst", 32'h40, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
